// File: rtl/tcs_freq_emulator.sv
// -----------------------------------------------------------------------------
// tcs_freq_emulator
//
// Synthesizable stand-in for a TCS3200-style colour sensor. It decodes the
// filter select CS and produces FREQ, a square wave whose period in clk
// cycles comes from one of four run-time loadable period registers. It feeds
// the colour path and freq_counter on the board, or in a bench, when the
// physical sensor is absent.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   reset       synchronous, active-high reset
//   CS[1:0]     filter select: 00 red, 01 blue, 10 clear, 11 green
//   OE          output enable; low forces FREQ low and parks the emulator
//   cfg_sel     period register to load (same encoding as CS)
//   cfg_period  period value to load, in clk cycles
//   cfg_load    one-cycle strobe writing cfg_period into register cfg_sel
//   FREQ        emulated sensor output (registered)
//   edge_pulse  one-cycle pulse in the cycle FREQ rises (registered)
//   active_sel  filter currently being emulated (registered)
//
// Each period of P cycles is split into hi = P>>1 cycles high followed by
// lo = P-hi cycles low, so an odd period gives its extra cycle to the low
// phase. After reset, a CS change or leaving the parked state, FREQ is held
// low for SETTLE_CYC cycles before the first rising edge.
// -----------------------------------------------------------------------------
module tcs_freq_emulator #(
    parameter int PER_W      = 19,
    parameter int SETTLE_CYC = 1000,
    parameter int RED_P      = 20000,
    parameter int GREEN_P    = 25000,
    parameter int BLUE_P     = 30000,
    parameter int CLEAR_P    = 8000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       CS,
    input  logic             OE,
    input  logic [1:0]       cfg_sel,
    input  logic [PER_W-1:0] cfg_period,
    input  logic             cfg_load,
    output logic             FREQ,
    output logic             edge_pulse,
    output logic [1:0]       active_sel
);

    localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0] SET_TERM = SET_W'(SETTLE_CYC - 1);
    localparam logic [PER_W-1:0] MIN_P    = PER_W'(2);
    localparam logic [PER_W-1:0] ONE_P    = PER_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       cs_q;
    logic [SET_W-1:0] settle_cnt;
    logic [PER_W-1:0] ph_cnt;
    logic [PER_W-1:0] hi_len;
    logic [PER_W-1:0] lo_len;
    logic [PER_W-1:0] per_reg [4];

    logic             cs_changed;
    logic             settle_done;
    logic             low_done;
    logic [PER_W-1:0] launch_per;
    logic [PER_W-1:0] cur_per;

    // High share of a period: the shorter half.
    function automatic logic [PER_W-1:0] split_hi(input logic [PER_W-1:0] p);
        return p >> 1;
    endfunction

    // Low share of a period: the remainder, which takes the odd cycle.
    function automatic logic [PER_W-1:0] split_lo(input logic [PER_W-1:0] p);
        return p - (p >> 1);
    endfunction

    always_comb begin
        cs_changed  = 1'b0;
        settle_done = 1'b0;
        low_done    = 1'b0;
        launch_per  = per_reg[active_sel];
        cur_per     = per_reg[cs_q];

        // A filter switch while parked is not an event: leaving the parked
        // state always goes through a full settle on the current cs_q anyway.
        cs_changed  = (state != ST_IDLE) && (CS != cs_q);
        settle_done = (state == ST_SETTLE) && (settle_cnt == SET_TERM);
        low_done    = (state == ST_LOW) && (ph_cnt == lo_len - ONE_P);

        // The first period after a settle uses the filter that was just
        // settled on; later periods re-read the register of the running filter.
        if (settle_done) begin
            launch_per = per_reg[cs_q];
        end
    end

    // hi_len/lo_len/ph_cnt are only consulted in HIGH/LOW, which are always
    // entered through a launch that loads them, so they carry no reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            cs_q       <= CS;
            active_sel <= 2'b00;
            FREQ       <= 1'b0;
            edge_pulse <= 1'b0;
            per_reg[0] <= PER_W'(RED_P);
            per_reg[1] <= PER_W'(BLUE_P);
            per_reg[2] <= PER_W'(CLEAR_P);
            per_reg[3] <= PER_W'(GREEN_P);
        end else begin
            cs_q       <= CS;
            edge_pulse <= 1'b0;

            // Register reads below see the pre-write value, so a load that
            // coincides with a period launch only affects later periods.
            if (cfg_load) begin
                per_reg[cfg_sel] <= cfg_period;
            end

            if (!OE) begin
                state <= ST_IDLE;
                FREQ  <= 1'b0;
            end else if (cs_changed) begin
                // Truncates any high pulse in progress, like the real part.
                active_sel <= CS;
                state      <= ST_SETTLE;
                settle_cnt <= '0;
                FREQ       <= 1'b0;
            end else if (settle_done || low_done) begin
                if (settle_done) begin
                    active_sel <= cs_q;
                end
                if (launch_per >= MIN_P) begin
                    state      <= ST_HIGH;
                    FREQ       <= 1'b1;
                    edge_pulse <= 1'b1;
                    ph_cnt     <= '0;
                    hi_len     <= split_hi(launch_per);
                    lo_len     <= split_lo(launch_per);
                end else begin
                    state <= ST_IDLE;
                    FREQ  <= 1'b0;
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (cur_per >= MIN_P) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                    ST_HIGH: begin
                        if (ph_cnt == hi_len - ONE_P) begin
                            state  <= ST_LOW;
                            FREQ   <= 1'b0;
                            ph_cnt <= '0;
                        end else begin
                            ph_cnt <= ph_cnt + ONE_P;
                        end
                    end
                    ST_LOW: begin
                        ph_cnt <= ph_cnt + ONE_P;
                    end
                    default: begin
                        state <= ST_IDLE;
                        FREQ  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tcs_freq_emulator.sv
// -----------------------------------------------------------------------------
// tb_tcs_freq_emulator
//
// Bench for tcs_freq_emulator with scaled-down parameters. A behavioural
// model tracks the emulated sensor as "cycles left in the current phase" and
// is compared with the DUT outputs every cycle; directed scenarios also pin
// phase lengths to hand-computed constants.
// -----------------------------------------------------------------------------
module tb_tcs_freq_emulator;

    localparam int PER_W = 19;
    localparam int S     = 20;
    localparam int RP    = 40;
    localparam int GP    = 50;
    localparam int BP    = 60;
    localparam int CP    = 16;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_HIGH   = 2;
    localparam int M_LOW    = 3;

    logic             clk        = 1'b0;
    logic             reset      = 1'b1;
    logic [1:0]       CS         = 2'b00;
    logic             OE         = 1'b1;
    logic [1:0]       cfg_sel    = 2'b00;
    logic [PER_W-1:0] cfg_period = '0;
    logic             cfg_load   = 1'b0;
    logic             FREQ;
    logic             edge_pulse;
    logic [1:0]       active_sel;

    int tests = 0;
    int fails = 0;

    tcs_freq_emulator #(
        .PER_W      (PER_W),
        .SETTLE_CYC (S),
        .RED_P      (RP),
        .GREEN_P    (GP),
        .BLUE_P     (BP),
        .CLEAR_P    (CP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .CS         (CS),
        .OE         (OE),
        .cfg_sel    (cfg_sel),
        .cfg_period (cfg_period),
        .cfg_load   (cfg_load),
        .FREQ       (FREQ),
        .edge_pulse (edge_pulse),
        .active_sel (active_sel)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_mode;
    int         m_left;
    int         m_hi;
    int         m_lo;
    int         m_per [4];
    logic [1:0] m_csq;
    logic [1:0] m_sel;
    logic       m_freq;
    logic       m_edge;
    bit         chk_en = 1'b0;

    task automatic m_launch(input int p);
        if (p >= 2) begin
            m_mode = M_HIGH;
            m_hi   = p / 2;
            m_lo   = p - m_hi;
            m_left = m_hi;
            m_freq = 1'b1;
            m_edge = 1'b1;
        end else begin
            m_mode = M_IDLE;
            m_freq = 1'b0;
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_per[0] = RP;
            m_per[1] = BP;
            m_per[2] = CP;
            m_per[3] = GP;
            m_mode   = M_SETTLE;
            m_left   = S;
            m_csq    = CS;
            m_sel    = 2'b00;
            m_freq   = 1'b0;
            m_edge   = 1'b0;
            chk_en   = 1'b1;
            return;
        end
        m_edge = 1'b0;
        if (!OE) begin
            m_mode = M_IDLE;
            m_freq = 1'b0;
        end else if (m_mode != M_IDLE && CS != m_csq) begin
            m_sel  = CS;
            m_mode = M_SETTLE;
            m_left = S;
            m_freq = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (m_per[m_csq] >= 2) begin
                        m_mode = M_SETTLE;
                        m_left = S;
                    end
                end
                M_SETTLE: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sel = m_csq;
                        m_launch(m_per[m_csq]);
                    end
                end
                M_HIGH: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_LOW;
                        m_left = m_lo;
                        m_freq = 1'b0;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_launch(m_per[m_sel]);
                end
            endcase
        end
        if (cfg_load) m_per[cfg_sel] = int'(cfg_period);
        m_csq = CS;
    endtask

    always @(posedge clk) model_step();

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({FREQ, edge_pulse, active_sel} !== {m_freq, m_edge, m_sel}) begin
                fails++;
                $display("FAIL cycle_check t=%0t dut freq/edge/sel=%b/%b/%0d model=%b/%b/%0d",
                         $time, FREQ, edge_pulse, active_sel, m_freq, m_edge, m_sel);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    // Count negedges (starting with the current one) while FREQ holds lvl.
    task automatic measure(input logic lvl, input int bound, output int n);
        n = 0;
        while (FREQ === lvl && n < bound) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic pulse_cfg(input logic [1:0] sel, input int per);
        cfg_sel    = sel;
        cfg_period = PER_W'(per);
        cfg_load   = 1'b1;
        @(negedge clk);
        cfg_load   = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("reset_freq", int'(FREQ), 0);
        check("reset_edge", int'(edge_pulse), 0);
        check("reset_sel", int'(active_sel), 0);

        // Red default: settle, then 20/20.
        reset = 1'b0;
        measure(1'b0, 200, n); check("settle_after_reset", n, S);
        check("first_edge", int'(edge_pulse), 1);
        measure(1'b1, 200, n); check("hi_red", n, RP / 2);
        measure(1'b0, 200, n); check("lo_red", n, RP - RP / 2);

        // Load 7 mid-high: the running period completes unchanged.
        repeat (5) @(negedge clk);
        pulse_cfg(2'b00, 7);
        measure(1'b1, 200, n); check("hi_in_progress", n, 14);
        measure(1'b0, 200, n); check("lo_old_period", n, 20);
        measure(1'b1, 200, n); check("hi_p7", n, 3);
        measure(1'b0, 200, n); check("lo_p7", n, 4);

        // Switch to green in the first high cycle.
        CS = 2'b11;
        @(negedge clk);
        check("cs_change_falls", int'(FREQ), 0);
        check("cs_change_sel", int'(active_sel), 3);
        measure(1'b0, 200, n); check("settle_after_cs", n, S);
        measure(1'b1, 200, n); check("hi_green", n, 25);

        // Drop OE mid-low, then raise it again.
        repeat (3) @(negedge clk);
        OE = 1'b0;
        @(negedge clk);
        check("oe_low", int'(FREQ), 0);
        repeat (10) @(negedge clk);
        OE = 1'b1;
        measure(1'b0, 200, n); check("settle_after_oe", n, S + 1);
        measure(1'b1, 200, n); check("hi_after_oe", n, 25);

        // Period 1 parks the emulator after the running low phase.
        pulse_cfg(2'b11, 1);
        measure(1'b0, 200, n); check("parked_stays_low", n, 200);
        pulse_cfg(2'b11, 2);
        measure(1'b0, 200, n); check("settle_after_p2", n, S + 1);
        measure(1'b1, 200, n); check("hi_p2", n, 1);
        measure(1'b0, 200, n); check("lo_p2", n, 1);
        measure(1'b1, 200, n); check("hi_p2_again", n, 1);

        // Blue at 500, reset mid-high restores the default.
        pulse_cfg(2'b01, 500);
        CS = 2'b01;
        @(negedge clk);
        measure(1'b0, 200, n); check("settle_blue", n, S);
        check("blue_sel", int'(active_sel), 1);
        repeat (10) @(negedge clk);
        check("blue_500_high", int'(FREQ), 1);
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort", int'(FREQ), 0);
        @(negedge clk);
        reset = 1'b0;
        measure(1'b0, 200, n); check("settle_after_reset2", n, S);
        measure(1'b1, 400, n); check("hi_blue_default", n, BP / 2);
        check("sel_after_reset2", int'(active_sel), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 999) < 3);
            OE       = ($urandom_range(0, 99) < 96);
            if ($urandom_range(0, 99) < 3) CS = 2'($urandom);
            cfg_load   = ($urandom_range(0, 99) < 4);
            cfg_sel    = 2'($urandom);
            cfg_period = PER_W'($urandom_range(0, 30));
            @(negedge clk);
        end
        reset    = 1'b0;
        cfg_load = 1'b0;
        OE       = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tcs_freq_emulator.md
Name: tcs_freq_emulator

Overview:
Synthesizable model of the TCS3200-style colour sensor, i.e. the sensor end of the CS/FREQ interface that the colour path and freq_counter consume.
- Decodes the filter select CS and drives FREQ as a square wave whose period, in clk cycles, is taken from a per-filter register.
- Used for on-board loopback and bench stimulus of the colour chain without the physical sensor.
- Period registers are loaded at run time through a simple strobe interface.

Parameters:
PER_W, 19, width of period registers (matches freq_counter period width)
SETTLE_CYC, 1000, clk cycles FREQ is held low after any CS change or enable
RED_P, 20000, reset value of red period register
GREEN_P, 25000, reset value of green period register
BLUE_P, 30000, reset value of blue period register
CLEAR_P, 8000, reset value of clear period register

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
CS  input  2  filter select: 00 red, 01 blue, 10 clear, 11 green
OE  input  1  output enable; low forces FREQ low
cfg_sel  input  2  register to load, same encoding as CS
cfg_period  input  PER_W  period value to load
cfg_load  input  1  one-cycle strobe; writes cfg_period into the register chosen by cfg_sel
FREQ  output  1  emulated sensor frequency output
edge_pulse  output  1  one-cycle pulse in the cycle FREQ rises
active_sel  output  2  CS value currently being emulated (registered)

Behaviour:
- Reset:
  - FREQ=0, edge_pulse=0, active_sel=00.
  - Period registers load their *_P defaults.
  - State=SETTLE, settle counter=0, cs_q=CS.
- Config:
  - On cfg_load, the selected register takes cfg_period on the next edge.
  - The new value applies only from the next HIGH-phase start; the period in progress is not altered.
- Period split: P = register selected by active_sel, latched at HIGH entry. hi = P>>1; lo = P-hi. Odd P gives the extra cycle to LOW.
- States:
  - IDLE: FREQ=0.
    - Enter when OE=0 (from any state) or when latched P<2.
    - Leave to SETTLE when OE=1 and the selected register is ≥2, re-checked every cycle.
  - SETTLE: FREQ=0; counter counts 0..SETTLE_CYC-1.
    - At terminal count, latch P. If P≥2 go to HIGH, else go to IDLE.
  - HIGH: FREQ=1 for exactly hi cycles, then LOW.
    - edge_pulse=1 in the first HIGH cycle only.
  - LOW: FREQ=0 for exactly lo cycles.
    - Then re-latch P from the register; go to HIGH if P≥2, else IDLE.
- CS change: cs_q registers CS each cycle. If CS≠cs_q in any state other than IDLE:
  - active_sel←CS, go to SETTLE, counter=0, FREQ=0 next cycle.
  - A partial high pulse is truncated, which matches the real sensor's glitch on filter switch.
- Priority, highest first: reset > OE=0 > CS change > normal sequencing.
- Simultaneous events:
  - cfg_load coincident with HIGH entry: the old value is latched.
  - A CS change during SETTLE restarts the counter at 0.
- FREQ and edge_pulse are registered outputs (no combinational path from inputs).
- Counter widths: phase counter PER_W bits, settle counter clog2(SETTLE_CYC+1). No wrap can occur because P fits PER_W.
- Reset mid-operation aborts any phase immediately. Loaded register values are lost (defaults restored).

Test Plan:
- Reset with CS=00, OE=1, SETTLE_CYC=1000 -> FREQ low 1000 cycles, then 10000 high / 10000 low repeating; edge_pulse once per 20000 cycles.
- cfg_sel=00, cfg_period=7 loaded mid-HIGH -> current period completes at 20000; following periods are 3 high / 4 low.
- CS 00→11 during HIGH phase -> FREQ falls next cycle; low for 1000 cycles; then 12500/12500; active_sel=11.
- OE dropped mid-LOW -> FREQ=0 next cycle and stays low. OE raised -> 1000-cycle settle, then a fresh full period.
- Load cfg_period=1 into the active register -> after the current LOW, state=IDLE, FREQ stays 0. Loading 2 -> settle then 1 high / 1 low toggling.
- Assert reset during HIGH after loading 500 into blue -> FREQ=0 next cycle; after release with CS=01 the period is 30000 (default restored).
